imem_stream_loader: RTL
=======================

# imem_stream_loader

Hardware program loader for the mips16 core: accepts 32-bit instruction words on a valid/ready stream and writes them byte-wise, big-endian, into the core's byte-addressed instruction memory from address 0. After the final word it appends the 0xFFFFFFFF halt sentinel word, then releases the core from reset. It is the write-side counterpart of the bench-side instruction decode/monitor path and replaces file-based memory preload in hardware bring-up.

## Interface
- ADDR_WIDTH, 8, instruction-memory byte-address width; capacity MAX_WORDS = 2**ADDR_WIDTH/4 words, including the sentinel.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  word present.
- in_ready  out  1  loader can take a word.
- in_data  in  32  instruction word.
- in_last  in  1  qualifies the final program word.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  ADDR_WIDTH  byte address.
- mem_wdata  out  8  byte data.
- cpu_reset  out  1  holds mips16 in reset while loading.
- done  out  1  load complete, sentinel written.
- overflow  out  1  program exceeded capacity.
- word_count  out  ADDR_WIDTH-1  program words accepted, excluding the sentinel.
- checksum  out  32  see Configuration.

## Operation
- States: IDLE, WRITE, HALT, DONE.
- IDLE: in_ready=1. A handshake (in_valid & in_ready) captures in_data and in_last into a holding register, increments word_count, and moves to WRITE.
- Capacity check: if in_valid is high in IDLE while word_count == MAX_WORDS-1, the word is not accepted (in_ready=0 that cycle), overflow sets sticky, and the FSM moves to HALT.
- WRITE: 4 cycles, byte k = 0..3. mem_addr = 4*w + k, where w is the word's index. mem_wdata = word[31-8k -: 8], so the MSB goes to the lowest address. mem_we=1 each cycle.
  - After k=3: go to HALT if the captured in_last = 1, otherwise go to IDLE.
- HALT: 4 cycles writing 0xFF to addresses 4*word_count .. 4*word_count+3, then go to DONE.
- DONE: in_ready=0, mem_we=0, done=1, cpu_reset=0. The FSM holds in DONE until reset; in_valid is ignored.
- Address arithmetic is ADDR_WIDTH wide. Because of the capacity check it never wraps.
- An empty program is not possible: at least one word with in_last=1 is required. The sentinel then lands at word 1.

## Timing
- Reset values (next edge after reset high):
  - State IDLE.
  - in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, done=0, overflow=0, word_count=0, checksum=0.
- All outputs are registered except in_ready, which is decoded from state and word_count.
- Handshake at edge N: byte writes are presented in cycles N+1..N+4. The next in_ready is at N+5, giving a throughput of 1 word per 5 cycles.
- Last word handshake at N: sentinel bytes are written in cycles N+5..N+8. done=1 and cpu_reset=0 from N+9.
- in_data and in_last are sampled only on the handshake edge. Changes while in_ready=0 have no effect.
- Reset mid-load: the FSM returns to IDLE with counters cleared. Bytes already written remain in memory, and no further mem_we is issued. cpu_reset=1 on the cycle after the reset edge.
- Reset has priority over every other event, including a handshake on the same edge.

## Configuration
- IMEM_LOADER_CHECKSUM_EN
  - Defined: checksum is the modulo-2^32 sum of all accepted program words, updated on the handshake edge. The sentinel and words rejected on overflow are excluded.
  - Undefined: checksum is tied to 0 and no adder is synthesized.

## Test plan
- Three-word program 0x2084001C, 0x00000000, 0x08000000 (last on third):
  - memory[0..3] = 20 84 00 1C and memory[8..11] = 08 00 00 00.
  - memory[12..15] = FF FF FF FF.
  - word_count=3; done and cpu_reset=0 exactly 9 cycles after the third handshake.
- in_valid held high continuously: in_ready pulses once per 5 cycles, mem_we is high 4 of every 5 cycles, and no word is dropped or duplicated.
- ADDR_WIDTH=4 (MAX_WORDS 4), 5 words with no last:
  - 3 words accepted, then overflow=1.
  - Sentinel at bytes 12..15; the 4th word is never written.
  - done=1, word_count=3.
- Reset asserted at the 2nd byte of word 1:
  - No mem_we from the next cycle; word_count=0, cpu_reset=1.
  - A reload of a single word 0x3C010005 with last=1 writes bytes 0..3, and the sentinel goes to 4..7.
- With IMEM_LOADER_CHECKSUM_EN, words 0xFFFFFFFF, 0x00000002 (last): checksum=0x00000001. Without the macro, checksum=0.
- In DONE, in_valid=1 with new data for 20 cycles: no writes, in_ready=0, and the memory image is unchanged.

Source files
------------

// File: rtl/imem_stream_loader_if.sv
// rtl/imem_stream_loader_if.sv - instruction word stream into the program loader
interface imem_stream_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - streams words big-endian into imem, appends halt sentinel, releases cpu
// Optional running word checksum enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_stream_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  imem_stream_loader_if.slave   in_if,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  output logic                  cpu_reset_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [ADDR_WIDTH-2:0] word_count_o,
  output logic [31:0]           checksum_o
);
  localparam int MAX_WORDS = (2 ** ADDR_WIDTH) / 4;
  localparam logic [ADDR_WIDTH-2:0] LAST_SLOT = (ADDR_WIDTH-1)'(MAX_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, HALT, DONE} state_e;

  state_e                state_q;
  logic [1:0]            byte_q;
  logic [31:0]           shift_q;
  logic                  last_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]            mem_wdata_q;
  logic                  cpu_reset_q;
  logic                  done_q;
  logic                  overflow_q;
  logic [ADDR_WIDTH-2:0] word_count_q;

  logic full;
  logic accept;

  // The last slot is reserved for the sentinel, so a word arriving there is refused.
  assign full           = (word_count_q == LAST_SLOT);
  assign in_if.in_ready = (state_q == IDLE) && !full;
  assign accept         = in_if.in_valid && in_if.in_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_we_q <= 1'b0;
          byte_q   <= '0;
          if (accept) begin
            state_q      <= WRITE;
            shift_q      <= {in_if.in_data[23:0], 8'h00};
            last_q       <= in_if.in_last;
            mem_we_q     <= 1'b1;
            mem_addr_q   <= ADDR_WIDTH'({word_count_q, 2'b00});
            mem_wdata_q  <= in_if.in_data[31:24];
            word_count_q <= word_count_q + 1'b1;
          end else if (in_if.in_valid && full) begin
            state_q     <= HALT;
            overflow_q  <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ADDR_WIDTH'({word_count_q, 2'b00});
            mem_wdata_q <= 8'hFF;
          end
        end
        WRITE: begin
          // Address keeps counting: after byte 3 it already points at the next word slot.
          byte_q     <= byte_q + 1'b1;
          mem_addr_q <= mem_addr_q + 1'b1;
          if (byte_q != 2'd3) begin
            mem_wdata_q <= shift_q[31:24];
            shift_q     <= {shift_q[23:0], 8'h00};
          end else if (last_q) begin
            state_q     <= HALT;
            mem_wdata_q <= 8'hFF;
          end else begin
            state_q  <= IDLE;
            mem_we_q <= 1'b0;
          end
        end
        HALT: begin
          byte_q <= byte_q + 1'b1;
          if (byte_q != 2'd3) begin
            mem_addr_q <= mem_addr_q + 1'b1;
          end else begin
            state_q     <= DONE;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
          end
        end
        default: begin
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + in_if.in_data;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign done_o       = done_q;
  assign overflow_o   = overflow_q;
  assign word_count_o = word_count_q;
endmodule
